// File: rtl/fx_comp_sched_if.sv
// Sample/parameter inputs and gain-applied outputs of the compressor gain sequencer.
interface fx_comp_sched_if #(
  parameter int DATA_W  = 16,
  parameter int PARAM_W = 8
);
  logic                            sample_en;
  logic signed [1:0][DATA_W-1:0]   audio_in;
  logic        [15:0]              envelope;
  logic        [PARAM_W-1:0]       fx_threshold;
  logic        [PARAM_W-1:0]       fx_ratio;
  logic signed [1:0][DATA_W-1:0]   audio_out;
  logic        [15:0]              gain;
  logic                            out_valid;
  logic                            busy;
  logic                            overrun;

  modport master (
    output sample_en, audio_in, envelope, fx_threshold, fx_ratio,
    input  audio_out, gain, out_valid, busy, overrun
  );

  modport slave (
    input  sample_en, audio_in, envelope, fx_threshold, fx_ratio,
    output audio_out, gain, out_valid, busy, overrun
  );
endinterface

// File: rtl/fx_comp_sched.sv
// Compressor gain sequencer sharing one 18x17 multiplier; out_valid 5 cycles after accept (21 when the ratio needs a divide).
// No backpressure: sample_en outside IDLE is dropped and flagged on overrun. FX_COMP_GAIN_SMOOTH_EN enables slew-limited gain.
module fx_comp_sched #(
  parameter int DATA_W  = 16,
  parameter int PARAM_W = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  fx_comp_sched_if.slave io_comp
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DIV    = 3'd1;
  localparam logic [2:0] S_GAIN   = 3'd2;
  localparam logic [2:0] S_SMOOTH = 3'd3;
  localparam logic [2:0] S_MUL_L  = 3'd4;
  localparam logic [2:0] S_MUL_R  = 3'd5;

  localparam int          MUL_A_W = DATA_W + 2;
  localparam int          MUL_B_W = 17;
  localparam int          PROD_W  = MUL_A_W + MUL_B_W;
  localparam logic [15:0] CF_MAX  = 16'd32440;
  localparam logic [15:0] GAIN_1  = 16'd32767;

  logic [2:0]                r_state;
  logic [DATA_W-1:0]         r_aud_l;
  logic [DATA_W-1:0]         r_aud_r;
  logic [15:0]               r_env;
  logic [PARAM_W-1:0]        r_thr;
  logic [PARAM_W-1:0]        r_ratio;
  logic [PARAM_W-1:0]        r_ratio_used;
  logic [15:0]               r_cf;
  logic [15:0]               r_target;
  logic [15:0]               r_gain;
  logic [DATA_W-1:0]         r_hold_l;
  logic [DATA_W-1:0]         r_out_l;
  logic [DATA_W-1:0]         r_out_r;
  logic                      r_out_valid;
  logic                      r_overrun;
  logic [15:0]               r_dvd;
  logic [PARAM_W-1:0]        r_rem;
  logic [14:0]               r_quo;
  logic [3:0]                r_cnt;

  logic                      w_in_range;
  logic [PARAM_W:0]          w_rem_sh;
  logic [PARAM_W:0]          w_rem_diff;
  logic                      w_qbit;
  logic [16:0]               w_thr_s;
  logic signed [16:0]        w_over;
  logic                      w_over_pos;
  logic signed [MUL_A_W-1:0] w_mul_a;
  logic signed [MUL_B_W-1:0] w_mul_b;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [PROD_W-1:0]  w_shr;
  logic [DATA_W-1:0]         w_sat;
  logic [15:0]               w_red_hi;
  logic [15:0]               w_target;
  logic [15:0]               w_gain_nx;

  assign w_in_range = (io_comp.fx_ratio >= PARAM_W'(2)) && (io_comp.fx_ratio <= PARAM_W'(99));

  // Restoring divider step: remainder < ratio, so the borrow bit alone decides the quotient bit.
  assign w_rem_sh   = {r_rem, r_dvd[15]};
  assign w_rem_diff = w_rem_sh - {1'b0, r_ratio};
  assign w_qbit     = ~w_rem_diff[PARAM_W];

  assign w_thr_s    = 17'({r_thr, 7'b0}) + 17'({r_thr, 1'b0});
  assign w_over     = $signed({1'b0, r_env} - w_thr_s);
  assign w_over_pos = ~w_over[16] && (w_over != 17'sd0);

  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      S_GAIN: begin
        w_mul_a = MUL_A_W'(w_over);
        w_mul_b = $signed({1'b0, r_cf});
      end
      S_MUL_L: begin
        w_mul_a = MUL_A_W'($signed(r_aud_l));
        w_mul_b = $signed({1'b0, r_gain});
      end
      S_MUL_R: begin
        w_mul_a = MUL_A_W'($signed(r_aud_r));
        w_mul_b = $signed({1'b0, r_gain});
      end
      default: begin
        w_mul_a = '0;
        w_mul_b = '0;
      end
    endcase
  end

  assign w_prod   = PROD_W'(w_mul_a) * PROD_W'(w_mul_b);
  assign w_shr    = w_prod >>> 15;
  assign w_red_hi = w_prod[30:15];

  always_comb begin
    w_sat = w_shr[DATA_W-1:0];
    if (w_shr > PROD_W'(32767))
      w_sat = DATA_W'(16'h7FFF);
    else if (w_shr < -PROD_W'(32768))
      w_sat = DATA_W'(16'h8000);
  end

  always_comb begin
    w_target = GAIN_1;
    if (w_over_pos) begin
      if (w_red_hi >= GAIN_1)
        w_target = 16'd100;
      else
        w_target = GAIN_1 - w_red_hi;
    end
  end

  always_comb begin
    w_gain_nx = r_target;
`ifdef FX_COMP_GAIN_SMOOTH_EN
    // Attack steps down by at most 128 per sample, release steps up by at most 32.
    if (r_gain > r_target)
      w_gain_nx = ((r_gain - r_target) > 16'd128) ? (r_gain - 16'd128) : r_target;
    else if (r_gain < r_target)
      w_gain_nx = ((r_target - r_gain) > 16'd32) ? (r_gain + 16'd32) : r_target;
    else
      w_gain_nx = r_gain;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_aud_l      <= '0;
      r_aud_r      <= '0;
      r_env        <= '0;
      r_thr        <= '0;
      r_ratio      <= '0;
      r_ratio_used <= PARAM_W'(1);
      r_cf         <= '0;
      r_target     <= GAIN_1;
      r_gain       <= GAIN_1;
      r_hold_l     <= '0;
      r_out_l      <= '0;
      r_out_r      <= '0;
      r_out_valid  <= 1'b0;
      r_overrun    <= 1'b0;
      r_dvd        <= '0;
      r_rem        <= '0;
      r_quo        <= '0;
      r_cnt        <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_overrun   <= io_comp.sample_en && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (io_comp.sample_en) begin
            r_aud_l <= io_comp.audio_in[0];
            r_aud_r <= io_comp.audio_in[1];
            r_env   <= io_comp.envelope;
            r_thr   <= io_comp.fx_threshold;
            r_ratio <= io_comp.fx_ratio;
            r_dvd   <= 16'h8000;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            if (w_in_range && (io_comp.fx_ratio != r_ratio_used)) begin
              r_state <= S_DIV;
            end else begin
              // An in-range ratio equal to ratio_used keeps the cf already computed for it.
              if (io_comp.fx_ratio < PARAM_W'(2))
                r_cf <= '0;
              else if (io_comp.fx_ratio > PARAM_W'(99))
                r_cf <= CF_MAX;
              r_ratio_used <= io_comp.fx_ratio;
              r_state      <= S_GAIN;
            end
          end
        end
        S_DIV: begin
          r_dvd <= {r_dvd[14:0], 1'b0};
          r_rem <= w_qbit ? w_rem_diff[PARAM_W-1:0] : w_rem_sh[PARAM_W-1:0];
          r_quo <= {r_quo[13:0], w_qbit};
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_cf         <= 16'd32768 - {r_quo, w_qbit};
            r_ratio_used <= r_ratio;
            r_state      <= S_GAIN;
          end
        end
        S_GAIN: begin
          r_target <= w_target;
          r_state  <= S_SMOOTH;
        end
        S_SMOOTH: begin
          r_gain  <= w_gain_nx;
          r_state <= S_MUL_L;
        end
        S_MUL_L: begin
          r_hold_l <= w_sat;
          r_state  <= S_MUL_R;
        end
        S_MUL_R: begin
          r_out_l     <= r_hold_l;
          r_out_r     <= w_sat;
          r_out_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_comp.audio_out = {r_out_r, r_out_l};
  assign io_comp.gain      = r_gain;
  assign io_comp.out_valid = r_out_valid;
  assign io_comp.busy      = (r_state != S_IDLE);
  assign io_comp.overrun   = r_overrun;

endmodule

// File: tb/tb_fx_comp_sched.sv
// Scoreboard bench for fx_comp_sched: directed samples with hand-computed outputs, gain and latency.
module tb_fx_comp_sched;

  typedef struct {
    int    l;
    int    r;
    int    g;
    int    lat;
    int    t0;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_out = 0;
  int   n_ovr = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fx_comp_sched_if #(.DATA_W(16), .PARAM_W(8)) bus ();

  fx_comp_sched #(.DATA_W(16), .PARAM_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io_comp (bus)
  );

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, req);
    end
  endtask

  task automatic send(input int l, input int r, input int env, input int thr, input int ratio,
                      input bit push, input int lat, input int el, input int er, input int eg,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    bus.audio_in[0]     = 16'(l);
    bus.audio_in[1]     = 16'(r);
    bus.envelope        = 16'(env);
    bus.fx_threshold    = 8'(thr);
    bus.fx_ratio        = 8'(ratio);
    bus.sample_en       = 1'b1;
    if (push) begin
      e.l = el; e.r = er; e.g = eg; e.lat = lat; e.t0 = cyc; e.name = nm;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.sample_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    check("drain_pending", sb.size(), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("busy_idle", int'(bus.busy), 0);
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, "_out_l"}, int'($signed(bus.audio_out[0])), 0);
    check({nm, "_out_r"}, int'($signed(bus.audio_out[1])), 0);
    check({nm, "_gain"}, int'(bus.gain), 32767);
    check({nm, "_busy"}, int'(bus.busy), 0);
    check({nm, "_vld"}, int'(bus.out_valid), 0);
    check({nm, "_ovr"}, int'(bus.overrun), 0);
  endtask

  // Output monitor: pops one expectation per out_valid pulse.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.overrun) n_ovr++;
      if (bus.out_valid) begin
        n_out++;
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_l"}, int'($signed(bus.audio_out[0])), e.l);
          check({e.name, "_r"}, int'($signed(bus.audio_out[1])), e.r);
          check({e.name, "_gain"}, int'(bus.gain), e.g);
          check({e.name, "_latency"}, cyc - e.t0, e.lat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n          = 1'b0;
    bus.sample_en    = 1'b0;
    bus.audio_in     = '0;
    bus.envelope     = '0;
    bus.fx_threshold = '0;
    bus.fx_ratio     = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_reset_state("reset");

    // Ratio 1: cf=0, no gain reduction; 16384*32767>>15 = 16383, -16384*32767>>>15 = -16384
    send(16384, -16384, 20000, 100, 1, 1'b1, 5, 16383, -16384, 32767, "below_thr");
    @(negedge clk);
    check("busy_cycle1", int'(bus.busy), 1);
    drain();

    // Ratio 4: cf=24576, over=7000, red>>15=5250, target=27517
    send(16384, -16384, 20000, 100, 4, 1'b1, 21, 13758, -13759, 27517, "ratio4_div");
    drain();
    send(32767, -32768, 20000, 100, 4, 1'b1, 5, 27516, -27517, 27517, "ratio4_repeat");
    drain();

    // Ratio 200: cf=32440, over=32767, red>>15=32439, target=328
    send(32767, -32768, 32767, 0, 200, 1'b1, 5, 327, -328, 328, "ratio200");
    drain();

    // Overrun: second strobe lands in MUL_L and must be dropped
    send(1000, -1000, 32767, 0, 200, 1'b1, 5, 10, -11, 328, "ovr_first");
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.audio_in[0]  = 16'sd5000;
    bus.audio_in[1]  = 16'sd5000;
    bus.envelope     = 16'd20000;
    bus.fx_threshold = 8'd100;
    bus.fx_ratio     = 8'd4;
    bus.sample_en    = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_en = 1'b0;
    @(negedge clk);
    check("overrun_cycle4", int'(bus.overrun), 1);
    drain();

    // Reset in the middle of a divide, then a clean ratio-4 sample must re-divide
    send(16384, -16384, 20000, 100, 4, 1'b0, 0, 0, 0, 0, "aborted");
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("busy_div8", int'(bus.busy), 1);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_reset_state("mid_div_reset");
    send(16384, -16384, 20000, 100, 4, 1'b1, 21, 13758, -13759, 27517, "after_reset");
    drain();

    check("out_valid_count", n_out, 6);
    check("overrun_count", n_ovr, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fx_comp_sched.md
# fx_comp_sched

Multi-cycle sequencer for the compressor gain path. It time-shares one signed multiplier across three jobs per sample: gain computation, left-channel gain application and right-channel gain application. It also computes the ratio-dependent compression factor with a serial divider instead of a combinational one. It sits after the envelope follower in the compressor effect slot and produces the gain-applied stereo output once per `sample_en`.

## Interface
- `DATA_W`, 16, audio sample width (signed, Q15).
- `PARAM_W`, 8, width of user parameters.
- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `sample_en`  in  1  one-cycle strobe; one audio sample per strobe.
- `audio_in`  in  [1:0][DATA_W-1:0] signed  stereo sample; [0]=L, [1]=R.
- `envelope`  in  16  unsigned peak envelope, 0..32767.
- `fx_threshold`  in  PARAM_W  threshold code.
- `fx_ratio`  in  PARAM_W  compression ratio code.
- `audio_out`  out  [1:0][DATA_W-1:0] signed  gain-applied stereo sample.
- `gain`  out  16  current applied gain, Q15.
- `out_valid`  out  1  one-cycle pulse when `audio_out` updates.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `overrun`  out  1  one-cycle pulse when a `sample_en` is dropped.

## Operation
**States:** IDLE, DIV, GAIN, SMOOTH, MUL_L, MUL_R.

**IDLE**
- When `sample_en` is high, register `audio_in`, `envelope`, `fx_threshold` and `fx_ratio`.
- Compression factor `cf` (16b), with registered ratio `r`:
  - `r` <= 1: `cf`=0.
  - `r` >= 100: `cf`=32440.
  - Otherwise `cf` = 32768 − floor(32768/`r`).
- Held register `ratio_used` records the ratio `cf` was last computed for.
- Next state:
  - `r` in 2..99 and `r` != `ratio_used`: go to DIV.
  - Otherwise: load `cf` directly for the out-of-range cases, set `ratio_used` <= `r`, go to GAIN.

**DIV**
- 16-iteration restoring division of 32768 by `r`, one quotient bit per cycle, MSB first.
- On the 16th cycle: `cf` <= 32768 − quotient, `ratio_used` <= `r`, go to GAIN.

**GAIN**
- `thr_s` = (`thr`<<7) + (`thr`<<1), i.e. `thr`×130.
- `over` = `env` − `thr_s`, 17b signed.
- Shared multiplier computes `red` = `over`×`cf`; `red` is 32b, and only meaningful when `over`>0.
- `target`:
  - `over` <= 0: 32767.
  - `over` > 0 and `red`[30:15] >= 32767: 100.
  - Otherwise: 32767 − `red`[30:15].

**SMOOTH**
- Update `gain` toward `target` (see Configuration). Go to MUL_L.

**MUL_L**
- Multiplier computes L × signed({0,`gain`}).
- Store sat16(prod >>> 15) into an internal L holding register.

**MUL_R**
- Same operation for R.
- At this edge, `audio_out`[0] <= L holding register, `audio_out`[1] <= R result; both update on the same edge.
- Pulse `out_valid`. Return to IDLE.

**Arithmetic**
- One physical multiplier, 18×17 signed; operands are zero/sign extended as needed.
- sat16 clamps the result to [−32768, 32767].

**Boundary cases**
- `sample_en` while not in IDLE: sample ignored, registers unchanged, `overrun` pulses on the next cycle.
- `sample_en` in the MUL_R cycle counts as an overrun.
- Parameter changes mid-sequence have no effect until the next accepted sample.
- Reset in any state:
  - Return to IDLE; `audio_out`=0, `gain`=32767, `out_valid`=0, `busy`=0, `overrun`=0.
  - `ratio_used`=1, `cf`=0, so the next in-range ratio re-divides.

## Timing
- Accept edge = cycle 0.
- No DIV:
  - GAIN=1, SMOOTH=2, MUL_L=3, MUL_R=4.
  - `out_valid` high and new `audio_out` visible in cycle 5.
  - `busy` high cycles 1–4.
- With DIV:
  - DIV=cycles 1–16, GAIN=17, SMOOTH=18, MUL_L=19, MUL_R=20.
  - Output visible in cycle 21.
  - `busy` high cycles 1–20.
- Minimum `sample_en` spacing without overrun: 5 cycles, or 21 cycles after a ratio change.
- `gain` updates at the end of SMOOTH and is held otherwise.

## Configuration
- **`FX_COMP_GAIN_SMOOTH_EN` defined:**
  - When `gain` > `target`: `gain` -= min(128, `gain`−`target`).
  - When `gain` < `target`: `gain` += min(32, `target`−`gain`).
  - Equal: hold.
- **Undefined:** `gain` <= `target` in SMOOTH.
- SMOOTH is traversed in both builds, so latency is identical.

## Test plan
- **Reset:** Assert `reset_n`=0 for 2 cycles. Required: `audio_out`=0/0, `gain`=0x7FFF, `busy`=0, `out_valid`=0.
- **Below threshold:**
  - Stimulus: `fx_ratio`=1, `envelope`=20000, `fx_threshold`=100, L=16384, R=−16384.
  - Required: `out_valid` in cycle 5, `audio_out`=16383/−16384, `gain`=32767.
- **First in-range ratio:**
  - Stimulus: `fx_ratio`=4, `envelope`=20000, `fx_threshold`=100.
  - Required: DIV for 16 cycles, `cf`=24576, `target`=27517, `out_valid` in cycle 21.
  - `gain` is 32639 with smoothing, 27517 without.
  - Repeat the same ratio: latency 5.
- **Near-infinite ratio:**
  - Stimulus: `fx_ratio`=200, `envelope`=32767, `fx_threshold`=0.
  - Required: no DIV, `target`=328; without smoothing, L=32767 gives out=327.
- **Overrun:** Stimulus: `sample_en` at cycles 0 and 3. Required: `overrun` pulses in cycle 4, exactly one `out_valid`, outputs reflect the cycle-0 sample.
- **Reset mid-DIV:** Stimulus: assert reset at DIV cycle 8, release, send `fx_ratio`=4. Required: full 16-cycle DIV repeats and the output matches the clean-run result.
